// File: rtl/sgdmac_rd_arbiter.sv
// sgdmac_rd_arbiter: two-port AXI read arbiter for the SG-DMA controller.
// Port 0 is the descriptor fetcher, port 1 the data read engine. One burst
// is outstanding at a time: IDLE picks a winner, ADDR forwards its AR
// request, DATA routes R beats back to it until m_rlast.
// Optional build macro: SGDMAC_RD_ARB_FIXED_PRIO_EN -- when defined, port 0
// always wins a tie (fixed priority); otherwise ties alternate round-robin.
module sgdmac_rd_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // port 0 (descriptor fetcher)
    input  logic [ID_W-1:0]   s0_arid,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [3:0]        s0_arlen,
    input  logic [2:0]        s0_arsize,
    input  logic [1:0]        s0_arburst,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [ID_W-1:0]   s0_rid,
    output logic [31:0]       s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    // port 1 (data read engine)
    input  logic [ID_W-1:0]   s1_arid,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [3:0]        s1_arlen,
    input  logic [2:0]        s1_arsize,
    input  logic [1:0]        s1_arburst,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [ID_W-1:0]   s1_rid,
    output logic [31:0]       s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    // shared master
    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [3:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    // status
    output logic              busy_o,
    output logic              grant_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic        grant_r, grant_s;
    logic        last_r,  last_s;
    logic [3:0]  cnt_r,   cnt_s;
    logic        err_r,   err_s;
    logic        win_s;
    logic        ar_hs_s;
    logic        r_hs_s;

    // Pick the winner among the current requesters.
    always_comb begin
        win_s = 1'b0;
        if (s0_arvalid && s1_arvalid) begin
`ifdef SGDMAC_RD_ARB_FIXED_PRIO_EN
            win_s = 1'b0;
`else
            win_s = ~last_r;
`endif
        end else if (s1_arvalid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Route AR and R channels according to state and grant; reset blanks all valids/readies.
    always_comb begin
        m_arid     = grant_r ? s1_arid    : s0_arid;
        m_araddr   = grant_r ? s1_araddr  : s0_araddr;
        m_arlen    = grant_r ? s1_arlen   : s0_arlen;
        m_arsize   = grant_r ? s1_arsize  : s0_arsize;
        m_arburst  = grant_r ? s1_arburst : s0_arburst;
        m_arvalid  = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        m_rready   = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        s0_rid     = m_rid;
        s0_rdata   = m_rdata;
        s0_rresp   = m_rresp;
        s0_rlast   = m_rlast;
        s1_rid     = m_rid;
        s1_rdata   = m_rdata;
        s1_rresp   = m_rresp;
        s1_rlast   = m_rlast;
        if (rst_n && (state_r == ST_ADDR)) begin
            m_arvalid  = grant_r ? s1_arvalid : s0_arvalid;
            s0_arready = ~grant_r & m_arready;
            s1_arready =  grant_r & m_arready;
        end else if (rst_n && (state_r == ST_DATA)) begin
            m_rready  = grant_r ? s1_rready : s0_rready;
            s0_rvalid = ~grant_r & m_rvalid;
            s1_rvalid =  grant_r & m_rvalid;
        end else begin
            m_arvalid = 1'b0;
            m_rready  = 1'b0;
        end
    end

    assign ar_hs_s = m_arvalid & m_arready;
    assign r_hs_s  = m_rvalid & m_rready;

    // Next-state, grant, beat counter and protocol-error evaluation.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        last_s  = last_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (s0_arvalid || s1_arvalid) begin
                    grant_s = win_s;
                    state_s = ST_ADDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (ar_hs_s) begin
                    cnt_s   = m_arlen;
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (r_hs_s) begin
                    if (cnt_r != 4'd0) begin
                        cnt_s = cnt_r - 4'd1;
                    end else begin
                        cnt_s = 4'd0;
                    end
                    // rlast must coincide exactly with the counter reaching zero
                    if ((m_rlast && (cnt_r != 4'd0)) || (!m_rlast && (cnt_r == 4'd0))) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_r;
                    end
                    if (m_rlast) begin
                        last_s  = grant_r;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; last-served starts at 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            grant_r <= 1'b0;
            last_r  <= 1'b1;
            cnt_r   <= 4'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            last_r  <= last_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
        end
    end

    assign busy_o  = (state_r != ST_IDLE);
    assign grant_o = grant_r;
    assign err_o   = err_r;

endmodule

// File: tb/tb_sgdmac_rd_arbiter.sv
// Directed self-checking bench for sgdmac_rd_arbiter. Inputs change on the
// falling clock edge; outputs are sampled 1 time unit later.
module tb_sgdmac_rd_arbiter;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
`ifdef SGDMAC_RD_ARB_FIXED_PRIO_EN
    localparam logic TIE_SECOND = 1'b0;
`else
    localparam logic TIE_SECOND = 1'b1;
`endif

    logic              clk;
    logic              rst_n;
    logic [ID_W-1:0]   s0_arid, s1_arid, m_arid, s0_rid, s1_rid, m_rid;
    logic [ADDR_W-1:0] s0_araddr, s1_araddr, m_araddr;
    logic [3:0]        s0_arlen, s1_arlen, m_arlen;
    logic [2:0]        s0_arsize, s1_arsize, m_arsize;
    logic [1:0]        s0_arburst, s1_arburst, m_arburst;
    logic              s0_arvalid, s1_arvalid, m_arvalid;
    logic              s0_arready, s1_arready, m_arready;
    logic [31:0]       s0_rdata, s1_rdata, m_rdata;
    logic [1:0]        s0_rresp, s1_rresp, m_rresp;
    logic              s0_rlast, s1_rlast, m_rlast;
    logic              s0_rvalid, s1_rvalid, m_rvalid;
    logic              s0_rready, s1_rready, m_rready;
    logic              busy_o, grant_o, err_o;

    int n_checks;
    int n_errors;

    sgdmac_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
        .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid),
        .s0_arready(s0_arready), .s0_rid(s0_rid), .s0_rdata(s0_rdata),
        .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid),
        .s0_rready(s0_rready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
        .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid),
        .s1_arready(s1_arready), .s1_rid(s1_rid), .s1_rdata(s1_rdata),
        .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid),
        .s1_rready(s1_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .busy_o(busy_o), .grant_o(grant_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Hold reset for two edges, check reset outputs, release on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",   busy_o,     1'b0);
        chk("rst_grant",  grant_o,    1'b0);
        chk("rst_err",    err_o,      1'b0);
        chk("rst_arvld",  m_arvalid,  1'b0);
        chk("rst_rready", m_rready,   1'b0);
        chk("rst_s0ardy", s0_arready, 1'b0);
        chk("rst_s1rvld", s1_rvalid,  1'b0);
        rst_n = 1'b1;
    endtask

    // One complete burst; starts and ends on a falling edge with the FSM idle.
    task automatic burst(input logic r0, input logic r1, input logic exp_g,
                         input logic [3:0] len, input int nbeats, input int stall,
                         input logic exp_err);
        logic [31:0] exp_addr;
        logic [31:0] dat;
        exp_addr = exp_g ? 32'h0000_2000 : 32'h0000_1000;
        s0_arvalid = r0; s1_arvalid = r1;
        s0_arlen = len;  s1_arlen = len;
        m_arready = (stall == 0);
        #1;
        chk("idle_no_ar", m_arvalid, 1'b0);
        chk("idle_busy",  busy_o,    1'b0);
        @(negedge clk); #1;
        chk("grant",      grant_o,   exp_g);
        chk("ar_valid",   m_arvalid, 1'b1);
        chk("ar_addr",    m_araddr,  exp_addr);
        chk("ar_len",     m_arlen,   len);
        for (int k = 0; k < stall; k++) begin
            chk("stall_addr",  m_araddr,   exp_addr);
            chk("stall_vld",   m_arvalid,  1'b1);
            chk("stall_s0rdy", s0_arready, 1'b0);
            chk("stall_s1rdy", s1_arready, 1'b0);
            @(negedge clk); #1;
        end
        m_arready = 1'b1;
        #1;
        chk("gnt_ardy",   exp_g ? s1_arready : s0_arready, 1'b1);
        chk("other_ardy", exp_g ? s0_arready : s1_arready, 1'b0);
        @(negedge clk);
        m_arready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            dat = 32'hD000_0000 + 32'(i) + (exp_g ? 32'h0000_0100 : 32'h0000_0000);
            m_rvalid = 1'b1;
            m_rlast  = (i == nbeats - 1);
            m_rdata  = dat;
            m_rid    = 4'(i + 3);
            #1;
            chk("gnt_rvld",   exp_g ? s1_rvalid : s0_rvalid, 1'b1);
            chk("other_rvld", exp_g ? s0_rvalid : s1_rvalid, 1'b0);
            chk("rdata",      exp_g ? s1_rdata  : s0_rdata,  dat);
            chk("rid",        exp_g ? s1_rid    : s0_rid,    4'(i + 3));
            chk("m_rready",   m_rready, 1'b1);
            @(negedge clk);
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        chk("done_busy",  busy_o,  1'b0);
        chk("done_err",   err_o,   exp_err);
        chk("done_grant", grant_o, exp_g);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        s0_arid = 4'h1; s0_araddr = 32'h0000_1000; s0_arlen = 4'd3;
        s0_arsize = 3'd2; s0_arburst = 2'd1; s0_arvalid = 1'b0; s0_rready = 1'b1;
        s1_arid = 4'h2; s1_araddr = 32'h0000_2000; s1_arlen = 4'd3;
        s1_arsize = 3'd2; s1_arburst = 2'd1; s1_arvalid = 1'b0; s1_rready = 1'b1;
        m_arready = 1'b0; m_rid = 4'h0; m_rdata = 32'h0; m_rresp = 2'b10;
        m_rlast = 1'b0; m_rvalid = 1'b0;

        do_reset();
        // port 0 alone, 4-beat burst at 0x1000
        burst(1'b1, 1'b0, 1'b0, 4'd3, 4, 0, 1'b0);
        chk("rresp_pass", s0_rresp, 2'b10);

        // both request together after reset, then keep requesting
        do_reset();
        burst(1'b1, 1'b1, 1'b0,       4'd1, 2, 0, 1'b0);
        burst(1'b1, 1'b1, TIE_SECOND, 4'd1, 2, 0, 1'b0);
        burst(1'b1, 1'b1, 1'b0,       4'd1, 2, 0, 1'b0);
        burst(1'b1, 1'b1, TIE_SECOND, 4'd1, 2, 0, 1'b0);
        // single requester wins regardless of history
        burst(1'b0, 1'b1, 1'b1, 4'd2, 3, 0, 1'b0);
        // AR stalled for 5 cycles while both request
        burst(1'b1, 1'b1, 1'b0, 4'd1, 2, 5, 1'b0);
        // early rlast on 2nd of 4 beats -> error, sticky afterwards
        burst(1'b0, 1'b1, 1'b1, 4'd3, 2, 0, 1'b1);
        burst(1'b1, 1'b0, 1'b0, 4'd0, 1, 0, 1'b1);

        // reset during beat 2 of a data phase
        s0_arvalid = 1'b1; s1_arvalid = 1'b0; s0_arlen = 4'd3; m_arready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        s0_arvalid = 1'b0; m_arready = 1'b0;
        m_rvalid = 1'b1; m_rlast = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s0rvld", s0_rvalid, 1'b0);
        chk("mid_rst_rready", m_rready,  1'b0);
        @(negedge clk); #1;
        chk("post_rst_busy",  busy_o,    1'b0);
        chk("post_rst_err",   err_o,     1'b0);
        chk("post_rst_grant", grant_o,   1'b0);
        chk("post_rst_arvld", m_arvalid, 1'b0);
        chk("post_rst_rvld",  s0_rvalid, 1'b0);
        rst_n = 1'b1;
        m_rvalid = 1'b0;
        burst(1'b0, 1'b1, 1'b1, 4'd3, 4, 0, 1'b0);
        // extra beat with counter at zero and no rlast -> error
        burst(1'b1, 1'b0, 1'b0, 4'd0, 2, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
